coin_feeder: RTL and testbench

COIN_FEEDER -- requirements
Module: coin_feeder

---
 rtl/vend_pkg.sv | 16 +
 rtl/coin_feeder.sv | 142 ++++++++++++++
 tb/tb_coin_feeder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending definitions: feeder states, coin symbols, default size
package vend_pkg;

    localparam int MAX_COINS_DEFAULT = 4;

    localparam logic COIN_SMALL = 1'b0;
    localparam logic COIN_LARGE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/coin_feeder.sv
// rtl/coin_feeder.sv - feeds a latched coin sequence into the recognizer and records the outcome
module coin_feeder
    import vend_pkg::*;
#(
    parameter int MAX_COINS = MAX_COINS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MAX_COINS-1:0] coin_seq,
    input  logic [2:0]           coin_len,
    input  logic                 out,
    input  logic                 rtrn,
    output logic                 x0,
    output logic                 x1,
    output logic                 rec_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 sale,
    output logic                 change,
    output logic                 timeout,
    output logic [2:0]           coins_used
);

    localparam logic [2:0] MAX_LEN = 3'(MAX_COINS);

    feeder_state_t state;
    feeder_state_t state_next;

    // seq_q shifts right once per SEND cycle, so bit 0 is always the symbol being sent
    logic [MAX_COINS-1:0] seq_q;
    logic [2:0]           len_q;
    logic [2:0]           cnt;
    logic [2:0]           len_eff;
    logic                 accept;
    logic                 take_sale;
    logic                 take_timeout;

    // Oversized requests are clamped to the largest sequence we can hold
    always_comb begin
        len_eff = (coin_len > MAX_LEN) ? MAX_LEN : coin_len;
    end

    // State register; reset drops straight to IDLE, which forces every output to its idle value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; out seen at the end of SEND cycle 0 is stale and ignored
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        take_sale    = 1'b0;
        take_timeout = 1'b0;
        x0           = 1'b0;
        x1           = 1'b0;
        rec_rst      = 1'b1;
        busy         = 1'b1;
        done         = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start && (coin_len != 3'd0)) begin
                    accept     = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                rec_rst = 1'b0;
                if (cnt == 3'd0) begin
                    x0 = seq_q[0];
                end else begin
                    x1 = seq_q[0];
                end
                if ((cnt != 3'd0) && out) begin
                    take_sale  = 1'b1;
                    state_next = ST_DONE;
                end else if (cnt == (len_q - 3'd1)) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                rec_rst = 1'b0;
                if (out) begin
                    take_sale = 1'b1;
                end else begin
                    take_timeout = 1'b1;
                end
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Transaction datapath: latch request, step through symbols, record the result until the next start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q      <= '0;
            len_q      <= 3'd0;
            cnt        <= 3'd0;
            sale       <= 1'b0;
            change     <= 1'b0;
            timeout    <= 1'b0;
            coins_used <= 3'd0;
        end else begin
            if (accept) begin
                seq_q      <= coin_seq;
                len_q      <= len_eff;
                cnt        <= 3'd0;
                sale       <= 1'b0;
                change     <= 1'b0;
                timeout    <= 1'b0;
                coins_used <= 3'd0;
            end else if (state == ST_SEND) begin
                cnt   <= cnt + 3'd1;
                seq_q <= seq_q >> 1;
            end
            if (take_sale) begin
                sale       <= 1'b1;
                change     <= rtrn;
                coins_used <= cnt;
            end
            if (take_timeout) begin
                timeout    <= 1'b1;
                sale       <= 1'b0;
                change     <= 1'b0;
                coins_used <= len_q;
            end
        end
    end

endmodule

// File: tb/tb_coin_feeder.sv
// tb/tb_coin_feeder.sv - randomized scoreboard bench for coin_feeder with a behavioural recognizer
module tb_coin_feeder;
    import vend_pkg::*;

    localparam int MC = MAX_COINS_DEFAULT;

    typedef struct {
        logic [MC-1:0] seq;
        int            len;
        int            start_cyc;
        logic          sale;
        logic          change;
        logic          timeout;
        int            used;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [MC-1:0] coin_seq = '0;
    logic [2:0]    coin_len = 3'd0;
    logic          out;
    logic          rtrn;
    logic          x0, x1, rec_rst, busy, done, sale, change, timeout;
    logic [2:0]    coins_used;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t last;

    coin_feeder #(.MAX_COINS(MC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .coin_seq   (coin_seq),
        .coin_len   (coin_len),
        .out        (out),
        .rtrn       (rtrn),
        .x0         (x0),
        .x1         (x1),
        .rec_rst    (rec_rst),
        .busy       (busy),
        .done       (done),
        .sale       (sale),
        .change     (change),
        .timeout    (timeout),
        .coins_used (coins_used)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Recognizer credit table: the first coin (x0) and later coins (x1) carry different credit
    function automatic int coin_value(logic first_coin, logic sym);
        if (first_coin) return (sym == COIN_LARGE) ? 1 : 2;
        return (sym == COIN_LARGE) ? 2 : 1;
    endfunction

    // Behavioural recognizer: registered out/rtrn, held in reset by rec_rst
    int   credit = 0;
    logic first_coin = 1'b1;
    logic rec_out = 1'b0;
    logic rec_rtrn = 1'b0;
    logic inject = 1'b0;
    always @(posedge clk) begin
        if (rec_rst) begin
            credit     <= 0;
            first_coin <= 1'b1;
            rec_out    <= inject;
            rec_rtrn   <= 1'b0;
        end else begin
            credit     <= credit + coin_value(first_coin, first_coin ? x0 : x1);
            rec_out    <= (credit + coin_value(first_coin, first_coin ? x0 : x1)) >= 4;
            rec_rtrn   <= (credit + coin_value(first_coin, first_coin ? x0 : x1)) > 4;
            first_coin <= 1'b0;
        end
    end
    assign out  = rec_out;
    assign rtrn = rec_rtrn;

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic int clamp_len(logic [2:0] len);
        return (int'(len) > MC) ? MC : int'(len);
    endfunction

    // Transaction-level reference: accumulate credit per coin, stop at the first dispense
    function automatic exp_t model(logic [MC-1:0] seq, logic [2:0] len);
        exp_t e;
        int   cr = 0;
        int   n = clamp_len(len);
        e.seq = seq; e.len = n; e.start_cyc = 0;
        e.sale = 1'b0; e.change = 1'b0; e.timeout = 1'b1; e.used = n;
        for (int i = 0; i < n; i++) begin
            cr += coin_value(i == 0, seq[i]);
            if (cr >= 4) begin
                e.sale = 1'b1; e.change = (cr > 4); e.timeout = 1'b0; e.used = i + 1;
                break;
            end
        end
        return e;
    endfunction

    function automatic exp_t mk(logic s, logic c, logic t, int used);
        exp_t e;
        e.seq = '0; e.len = 0; e.start_cyc = 0;
        e.sale = s; e.change = c; e.timeout = t; e.used = used;
        return e;
    endfunction

    // Monitor: checks symbols while sending and the result on every done pulse
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("done_cycle", 32'(cyc - e.start_cyc), 32'(e.used + 1));
                check("sale", 32'(sale), 32'(e.sale));
                check("change", 32'(change), 32'(e.change));
                check("timeout", 32'(timeout), 32'(e.timeout));
                check("coins_used", 32'(coins_used), 32'(e.used));
                check("done_lines", {29'd0, rec_rst, x0, x1}, 32'b100);
            end
        end else if (busy) begin
            if (q.size() == 0) begin
                check("busy_without_txn", 32'(busy), 32'd0);
            end else begin
                int   off;
                logic ex0, ex1;
                off = cyc - q[0].start_cyc;
                ex0 = 1'b0;
                ex1 = 1'b0;
                if (off == 0) ex0 = q[0].seq[0];
                else if (off < q[0].len) ex1 = q[0].seq[off];
                check("send_lines", {29'd0, rec_rst, x0, x1}, {29'd0, 1'b0, ex0, ex1});
            end
        end
    end

    // Called at a negedge in IDLE; returns just after the accepting edge
    task automatic issue(logic [MC-1:0] seq, logic [2:0] len, logic stale, exp_t e);
        coin_seq = seq; coin_len = len; start = 1'b1; inject = stale;
        @(posedge clk);
        #1;
        inject = 1'b0;
        e.start_cyc = cyc; e.seq = seq; e.len = clamp_len(len);
        q.push_back(e);
        check("accept", 32'(busy), 32'd1);
    endtask

    task automatic finish_txn(exp_t e, logic disturb);
        bit seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen  = 1;
                start = 1'b0;
            end else begin
                start    = disturb && ($urandom_range(0, 2) == 0);
                coin_len = 3'($urandom_range(0, 7));
                coin_seq = MC'($urandom);
            end
        end
        if (!seen) begin
            check("done_seen", 32'd0, 32'd1);
            start = 1'b0;
        end
        @(negedge clk);
        check("idle_after_done", {30'd0, busy, rec_rst}, 32'b01);
        check("hold_flags", {25'd0, sale, change, timeout, 1'b0, coins_used},
              {25'd0, e.sale, e.change, e.timeout, 1'b0, 3'(e.used)});
        last = e;
    endtask

    task automatic run(logic [MC-1:0] seq, logic [2:0] len, logic stale, logic disturb, exp_t e);
        issue(seq, len, stale, e);
        finish_txn(e, disturb);
    endtask

    task automatic ignore_request(logic [2:0] len);
        coin_len = len; coin_seq = MC'($urandom); start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("zero_len_ignored", {30'd0, busy, done}, 32'd0);
            check("zero_len_hold", {25'd0, sale, change, timeout, 1'b0, coins_used},
                  {25'd0, last.sale, last.change, last.timeout, 1'b0, 3'(last.used)});
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        last = mk(1'b0, 1'b0, 1'b0, 0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {23'd0, x0, x1, rec_rst, busy, done, sale, change, timeout, coins_used},
              {23'd0, 9'b0_0_1_0_0_0_0_0, 3'd0});
        rst = 1'b1;
        @(negedge clk);

        // Reference sequences (bit i = symbol i)
        run(4'b0010, 3'd2, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 2));
        run(4'b0100, 3'd3, 1'b0, 1'b0, mk(1'b1, 1'b1, 1'b0, 3));
        run(4'b0111, 3'd3, 1'b0, 1'b1, mk(1'b1, 1'b1, 1'b0, 3));
        run(4'b0101, 3'd3, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b0, 3));
        run(4'b0001, 3'd1, 1'b1, 1'b1, mk(1'b0, 1'b0, 1'b1, 1));
        ignore_request(3'd0);
        run(4'b0001, 3'd7, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 4));

        // Asynchronous reset in the middle of SEND cycle 1, then start on the first edge after release
        e = model(4'b1111, 3'd4);
        issue(4'b1111, 3'd4, 1'b0, e);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_send_reset", {23'd0, x0, x1, rec_rst, busy, done, sale, change, timeout, coins_used},
              {23'd0, 9'b0_0_1_0_0_0_0_0, 3'd0});
        q.delete();
        last = mk(1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        e = model(4'b0110, 3'd4);
        run(4'b0110, 3'd4, 1'b0, 1'b1, e);

        for (int i = 0; i < 40; i++) begin
            logic [MC-1:0] s;
            logic [2:0]    l;
            s = MC'($urandom);
            l = 3'($urandom_range(0, 7));
            if (l == 3'd0) begin
                ignore_request(l);
            end else begin
                run(s, l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), model(s, l));
            end
        end

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
